// File: rtl/captura_entrada.sv
// captura_entrada: debounced push-button capture of board switches for a processor I/O read.
// The processor is stalled until a filtered press latches the switches; the release is filtered too.
module captura_entrada #(
  parameter int DEBOUNCE_CICLOS = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  switch_dado,
  input  logic        botao_enter,
  input  logic        IOE,
  input  logic        IOsel,
  output logic [31:0] saida_dado,
  output logic        dado_valido,
  output logic        espera
);
  typedef enum logic [2:0] {
    OCIOSO, AGUARDA_APERTO, FILTRO_APERTO, ENTREGA, AGUARDA_SOLTAR, FILTRO_SOLTAR
  } estado_t;
  localparam logic [15:0] LIM = 16'(DEBOUNCE_CICLOS - 1);
  estado_t     estado_q, estado_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] dado_q, dado_d;
  logic [1:0]  btn_q;
  logic [9:0]  sw1_q, sw2_q;
  logic        req, btn;
  assign req = IOE & IOsel;
  assign btn = btn_q[1];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q <= OCIOSO;
      cnt_q    <= '0;
      dado_q   <= '0;
      btn_q    <= 2'b11;
      sw1_q    <= '0;
      sw2_q    <= '0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      dado_q   <= dado_d;
      btn_q    <= {btn_q[0], botao_enter};
      sw1_q    <= switch_dado;
      sw2_q    <= sw1_q;
    end
  end
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    dado_d   = dado_q;
    case (estado_q)
      OCIOSO: begin
        cnt_d = '0;
        if (req) estado_d = AGUARDA_APERTO;
      end
      AGUARDA_APERTO: begin
        cnt_d = '0;
        if (!req) estado_d = OCIOSO;
        else if (!btn) estado_d = FILTRO_APERTO;
      end
      FILTRO_APERTO: begin
        cnt_d = '0;
        if (!req) estado_d = OCIOSO;
        else if (btn) estado_d = AGUARDA_APERTO;
        else if (cnt_q == LIM) begin
          dado_d   = {22'b0, sw2_q};
          estado_d = ENTREGA;
        end else cnt_d = cnt_q + 16'd1;
      end
      ENTREGA: begin
        cnt_d    = '0;
        estado_d = AGUARDA_SOLTAR;
      end
      AGUARDA_SOLTAR: begin
        cnt_d = '0;
        if (btn) estado_d = FILTRO_SOLTAR;
      end
      FILTRO_SOLTAR: begin
        cnt_d = '0;
        if (!btn) estado_d = AGUARDA_SOLTAR;
        else if (cnt_q == LIM) estado_d = OCIOSO;
        else cnt_d = cnt_q + 16'd1;
      end
      default: begin
        cnt_d    = '0;
        estado_d = OCIOSO;
      end
    endcase
  end
  assign saida_dado  = dado_q;
  assign dado_valido = estado_q == ENTREGA;
  assign espera      = req & (estado_q == OCIOSO || estado_q == AGUARDA_APERTO || estado_q == FILTRO_APERTO);
endmodule

// File: tb/tb_captura_entrada.sv
// tb_captura_entrada: directed and randomized stimulus checked against a run-length behavioural model.
module tb_captura_entrada;
  localparam int N = 4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  switch_dado = '0;
  logic        botao_enter = 1'b1;
  logic        IOE = 1'b0;
  logic        IOsel = 1'b0;
  logic [31:0] saida_dado;
  logic        dado_valido;
  logic        espera;
  int vectors = 0;
  int miscompares = 0;
  // model: phase 0 idle, 1 armed for a press, 2 delivering, 3 waiting for a release
  int          ph = 0;
  int          run = 0;
  logic [31:0] m_dado = '0;
  logic [1:0]  m_btn = 2'b11;
  logic [9:0]  m_sw1 = '0, m_sw2 = '0;
  int          captures = 0;

  captura_entrada #(.DEBOUNCE_CICLOS(N)) dut (
    .clk(clk), .rst_n(rst_n), .switch_dado(switch_dado), .botao_enter(botao_enter),
    .IOE(IOE), .IOsel(IOsel), .saida_dado(saida_dado), .dado_valido(dado_valido), .espera(espera)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic [9:0] sw, input logic b, input logic ioe, input logic ios);
    logic req;
    @(negedge clk);
    rst_n = r; switch_dado = sw; botao_enter = b; IOE = ioe; IOsel = ios;
    req = ioe & ios;
    #1;
    chk("espera", {31'b0, espera}, {31'b0, req & (ph == 0 || ph == 1)});
    chk("dado_valido", {31'b0, dado_valido}, {31'b0, ph == 2});
    chk("saida_dado", saida_dado, m_dado);
    if (!r) begin
      ph = 0; run = 0; m_dado = '0; m_btn = 2'b11; m_sw1 = '0; m_sw2 = '0;
    end else begin
      if (ph == 0) begin
        if (req) begin ph = 1; run = 0; end
      end else if (ph == 1) begin
        if (!req) ph = 0;
        else if (!m_btn[1]) begin
          run++;
          if (run == N + 1) begin m_dado = {22'b0, m_sw2}; ph = 2; captures++; end
        end else run = 0;
      end else if (ph == 2) begin
        ph = 3; run = 0;
      end else begin
        if (m_btn[1]) begin
          run++;
          if (run == N + 1) ph = 0;
        end else run = 0;
      end
      m_btn = {m_btn[0], b};
      m_sw2 = m_sw1;
      m_sw1 = sw;
    end
    @(posedge clk);
  endtask

  initial begin
    logic       b, ioe, ios;
    logic [9:0] sw;
    for (int i = 0; i < 3; i++) step(0, 10'h3FF, 1, 1, 1);
    // clean press with switches 2A5, held well past the filter, then released
    for (int i = 0; i < 14; i++) step(1, 10'h2A5, 0, 1, 1);
    for (int i = 0; i < 10; i++) step(1, 10'h2A5, 1, 1, 1);
    step(1, 10'h2A5, 1, 0, 0);
    // bounce during the press filter
    for (int i = 0; i < 3; i++) step(1, 10'h155, 1, 1, 1);
    step(1, 10'h155, 0, 1, 1); step(1, 10'h155, 0, 1, 1); step(1, 10'h155, 1, 1, 1);
    for (int i = 0; i < 10; i++) step(1, 10'h155, 0, 1, 1);
    for (int i = 0; i < 10; i++) step(1, 10'h155, 1, 0, 0);
    // long hold with req kept high: one capture only
    for (int i = 0; i < 40; i++) step(1, 10'h2A5, 0, 1, 1);
    for (int i = 0; i < 10; i++) step(1, 10'h2A5, 1, 1, 1);
    step(1, 10'h2A5, 1, 0, 0);
    // req dropped inside the press filter
    for (int i = 0; i < 4; i++) step(1, 10'h0F0, 0, 1, 1);
    for (int i = 0; i < 4; i++) step(1, 10'h0F0, 0, 0, 1);
    // reset mid-filter
    for (int i = 0; i < 4; i++) step(1, 10'h0F0, 0, 1, 1);
    step(0, 10'h0F0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(1, 10'h0F0, 1, 0, 0);
    // output direction with the button pressed
    for (int i = 0; i < 12; i++) step(1, 10'h3C3, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(1, 10'h3C3, 1, 1, 0);
    b = 1; ioe = 0; ios = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(9) == 0) b = ~b;
      if ($urandom_range(29) == 0) ioe = ~ioe;
      if ($urandom_range(39) == 0) ios = ~ios;
      sw = 10'($urandom);
      step($urandom_range(299) != 0, sw, b, ioe, ios);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/captura_entrada.md
CAPTURA_ENTRADA -- requirements
Module: captura_entrada

Interface
REQ-001 SHALL have parameter DEBOUNCE_CICLOS, default 50000, giving the stable-level cycles that qualify a button edge (range 2..65535).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port switch_dado  input  10  raw asynchronous board switches.
REQ-005 SHALL have port botao_enter  input  1  raw asynchronous push-button; 0 = pressed.
REQ-006 SHALL have port IOE  input  1  processor I/O instruction active.
REQ-007 SHALL have port IOsel  input  1  1 = input (read) direction, 0 = output.
REQ-008 SHALL have port saida_dado  output  32  last captured switch value, zero-extended.
REQ-009 SHALL have port dado_valido  output  1  one-cycle pulse marking a fresh capture.
REQ-010 SHALL have port espera  output  1  stall request to the processor.

Function
REQ-011 SHALL pass botao_enter and switch_dado through two-flop synchronizers before any use.
REQ-012 SHALL define req = IOE & IOsel, sampled each cycle.
REQ-013 SHALL implement FSM states OCIOSO, AGUARDA_APERTO, FILTRO_APERTO, ENTREGA, AGUARDA_SOLTAR, FILTRO_SOLTAR.
REQ-014 SHALL in OCIOSO move to AGUARDA_APERTO when req=1 and stay otherwise.
REQ-015 SHALL in AGUARDA_APERTO clear the 16-bit counter and move to FILTRO_APERTO when the synchronized button is 0.
REQ-016 SHALL in FILTRO_APERTO increment the counter while the synced button is 0, and return to AGUARDA_APERTO with counter cleared if it reads 1.
REQ-017 SHALL on the FILTRO_APERTO cycle where the counter equals DEBOUNCE_CICLOS-1 with the button still 0 load saida_dado = {22'b0, synced switch_dado} and move to ENTREGA.
REQ-018 SHALL in ENTREGA assert dado_valido=1 for exactly that cycle and move unconditionally to AGUARDA_SOLTAR.
REQ-019 SHALL in AGUARDA_SOLTAR clear the counter and move to FILTRO_SOLTAR when the synced button is 1.
REQ-020 SHALL in FILTRO_SOLTAR count cycles with the button at 1, return to AGUARDA_SOLTAR if it reads 0, and move to OCIOSO when the counter equals DEBOUNCE_CICLOS-1.
REQ-021 SHALL drive espera = req & (state is OCIOSO, AGUARDA_APERTO or FILTRO_APERTO), combinationally.
REQ-022 SHALL keep espera=0 in ENTREGA, so the processor completes the read in that cycle with saida_dado already valid.
REQ-023 SHALL, if req drops in AGUARDA_APERTO or FILTRO_APERTO, return to OCIOSO next cycle with no capture and saida_dado unchanged.
REQ-024 SHALL ignore req in ENTREGA, AGUARDA_SOLTAR and FILTRO_SOLTAR, so one held press yields exactly one capture.
REQ-025 SHALL treat a new req arriving during FILTRO_SOLTAR as pending: espera=0 until OCIOSO is reached, then normal handling.
REQ-026 SHALL hold saida_dado between captures regardless of IOE, IOsel or switch changes.
REQ-027 SHALL ignore button activity in OCIOSO; a press held from before req passes through FILTRO_APERTO normally.
REQ-028 SHALL never let the counter exceed DEBOUNCE_CICLOS-1 or wrap.

Reset
REQ-029 SHALL when rst_n=0 at a clock edge set state OCIOSO, counter 0, saida_dado 0, dado_valido 0, and synchronizer flops to button 1 and switches 0.
REQ-030 SHALL give reset priority over every transition, including mid-filter and in ENTREGA, with no capture pulse produced.
REQ-031 SHALL hold espera = req while in reset-state OCIOSO, then follow REQ-021.

Verification (DEBOUNCE_CICLOS=4)
REQ-032 SHALL cover: switches=10'h2A5, req=1, button held 0 -> espera=1 until ENTREGA, ENTREGA reached 4 filter cycles after first synced 0, saida_dado=32'h000002A5, dado_valido high 1 cycle.
REQ-033 SHALL cover: bounce 0,0,1,0,0,0,0 on button -> counter restarts at the 1, single capture, single dado_valido pulse.
REQ-034 SHALL cover: button held 0 for 40 cycles with req=1 throughout -> exactly one capture, espera=0 after ENTREGA until release filtered.
REQ-035 SHALL cover: req=1 then req dropped in FILTRO_APERTO -> OCIOSO, saida_dado keeps prior 32'h000002A5, no pulse.
REQ-036 SHALL cover: rst_n=0 for one edge in FILTRO_APERTO -> next cycle saida_dado=0, dado_valido=0, state OCIOSO.
REQ-037 SHALL cover: IOE=1, IOsel=0 with button pressed -> espera=0, no capture.
